// File: rtl/shader_texel_fetch.sv
// rtl/shader_texel_fetch.sv - texel address generation (wrap/clamp) and single-outstanding texture fetch
// IDLE accepts a coordinate pair, REQ issues the read, WAIT takes the data, OUT holds it for downstream.
module shader_texel_fetch #(
    parameter int TEX_W_LOG2 = 6,
    parameter int TEX_H_LOG2 = 6,
    parameter int TEXEL_W    = 16
) (
    input  logic                             aclk,
    input  logic                             aresetn,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [11:0]                      tu,
    input  logic [11:0]                      tv,
    input  logic                             clamp,
    output logic                             mem_req,
    input  logic                             mem_gnt,
    output logic [TEX_W_LOG2+TEX_H_LOG2-1:0] mem_addr,
    input  logic                             mem_rvalid,
    input  logic [TEXEL_W-1:0]               mem_rdata,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [TEXEL_W-1:0]               texel
);

    localparam int ADDR_W = TEX_W_LOG2 + TEX_H_LOG2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_OUT
    } state_t;

    state_t              state_q;
    logic                in_ready_q;
    logic                mem_req_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic                out_valid_q;
    logic [TEXEL_W-1:0]  texel_q;

    logic [TEX_W_LOG2-1:0] u_d;
    logic [TEX_H_LOG2-1:0] v_d;
    logic                  u_over;
    logic                  v_over;

    // Any set bit above the texture size means the coordinate lies past the last texel.
    assign u_over = (tu >> TEX_W_LOG2) != 12'd0;
    assign v_over = (tv >> TEX_H_LOG2) != 12'd0;

    always_comb begin
        u_d = tu[TEX_W_LOG2-1:0];
        v_d = tv[TEX_H_LOG2-1:0];
        if (clamp && u_over) begin
            u_d = '1;
        end
        if (clamp && v_over) begin
            v_d = '1;
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= S_IDLE;
            in_ready_q  <= 1'b1;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            out_valid_q <= 1'b0;
            texel_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        mem_addr_q <= {v_d, u_d};
                        in_ready_q <= 1'b0;
                        mem_req_q  <= 1'b1;
                        state_q    <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (mem_gnt) begin
                        mem_req_q <= 1'b0;
                        state_q   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid) begin
                        texel_q     <= mem_rdata;
                        out_valid_q <= 1'b1;
                        state_q     <= S_OUT;
                    end
                end
                S_OUT: begin
                    // in_ready only rises after this edge, so no input overlaps the output handshake.
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= S_IDLE;
                    end
                end
                default: begin
                    in_ready_q  <= 1'b1;
                    mem_req_q   <= 1'b0;
                    out_valid_q <= 1'b0;
                    state_q     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_req   = mem_req_q;
    assign mem_addr  = mem_addr_q;
    assign out_valid = out_valid_q;
    assign texel     = texel_q;

endmodule

// File: tb/tb_shader_texel_fetch.sv
// tb/tb_shader_texel_fetch.sv - vector table, directed corner sequences and randomized fetches for shader_texel_fetch
module tb_shader_texel_fetch;

    localparam int TW = 64;
    localparam int TH = 64;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [11:0] tu = '0;
    logic [11:0] tv = '0;
    logic        clamp = 1'b0;
    logic        mem_req;
    logic        mem_gnt = 1'b0;
    logic [11:0] mem_addr;
    logic        mem_rvalid = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] texel;

    int checks = 0;
    int errors = 0;

    shader_texel_fetch #(.TEX_W_LOG2(6), .TEX_H_LOG2(6), .TEXEL_W(16)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .in_valid(in_valid), .in_ready(in_ready),
        .tu(tu), .tv(tv), .clamp(clamp),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .texel(texel)
    );

    always #5 aclk = ~aclk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [11:0] tu;
        logic [11:0] tv;
        logic        cl;
        logic [15:0] rd;
        int          gd;
        int          rdd;
        int          od;
        logic [11:0] ea;
        logic [15:0] et;
    } vec_t;

    vec_t        vecs [12];
    logic [15:0] tex_mem [4096];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_in_ready"}, in_ready, 1);
        chk({nm, "_mem_req"}, mem_req, 0);
        chk({nm, "_mem_addr"}, mem_addr, 0);
        chk({nm, "_out_valid"}, out_valid, 0);
        chk({nm, "_texel"}, texel, 0);
    endtask

    // Reference addressing from the plain wrap/clamp rules.
    function automatic int model_addr(input int u_in, input int v_in, input bit cl);
        int u;
        int v;
        if (cl) begin
            u = (u_in >= TW) ? TW - 1 : u_in;
            v = (v_in >= TH) ? TH - 1 : v_in;
        end else begin
            u = u_in % TW;
            v = v_in % TH;
        end
        return v * TW + u;
    endfunction

    // One complete fetch starting in IDLE; gd/rdd/od are grant, data and output-ready stall cycles.
    task automatic fetch(input string nm, input logic [11:0] tu_v, input logic [11:0] tv_v, input logic cl,
                         input logic [15:0] rd, input int gd, input int rdd, input int od,
                         input logic [11:0] ea, input logic [15:0] et);
        int lat;
        chk({nm, "_in_ready_idle"}, in_ready, 1);
        in_valid = 1'b1;
        tu = tu_v;
        tv = tv_v;
        clamp = cl;
        step();
        lat = 1;
        in_valid = 1'b0;
        tu = 12'($urandom);
        tv = 12'($urandom);
        clamp = 1'($urandom);
        chk({nm, "_mem_req"}, mem_req, 1);
        chk({nm, "_mem_addr"}, mem_addr, ea);
        for (int i = 0; i < gd; i++) begin
            mem_rvalid = 1'($urandom);
            mem_rdata = 16'($urandom);
            step();
            lat++;
            chk({nm, "_req_held"}, mem_req, 1);
            chk({nm, "_addr_held"}, mem_addr, ea);
            chk({nm, "_in_ready_busy"}, in_ready, 0);
        end
        mem_rvalid = 1'b0;
        mem_gnt = 1'b1;
        step();
        lat++;
        mem_gnt = 1'b0;
        chk({nm, "_req_dropped"}, mem_req, 0);
        for (int i = 0; i < rdd; i++) begin
            step();
            lat++;
            chk({nm, "_no_out_yet"}, out_valid, 0);
        end
        mem_rvalid = 1'b1;
        mem_rdata = rd;
        step();
        lat++;
        mem_rvalid = 1'b0;
        mem_rdata = 16'($urandom);
        chk({nm, "_out_valid"}, out_valid, 1);
        chk({nm, "_latency"}, lat, 3 + gd + rdd);
        chk({nm, "_texel"}, texel, et);
        in_valid = 1'b1;
        for (int i = 0; i < od; i++) begin
            mem_rvalid = 1'b1;
            step();
            chk({nm, "_out_held"}, out_valid, 1);
            chk({nm, "_texel_held"}, texel, et);
            chk({nm, "_no_accept"}, in_ready, 0);
        end
        mem_rvalid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        in_valid = 1'b0;
        chk({nm, "_out_done"}, out_valid, 0);
        chk({nm, "_ready_again"}, in_ready, 1);
        chk({nm, "_no_overlap_req"}, mem_req, 0);
        chk({nm, "_addr_kept"}, mem_addr, ea);
    endtask

    initial begin
        int ea;
        int nreq;
        int nout;
        int nacc;
        logic [11:0] b2b_tu [3];
        logic [11:0] b2b_tv [3];
        logic [11:0] b2b_ea [3];

        vecs[0]  = '{12'h045, 12'h0C3, 1'b0, 16'hBEEF, 0, 0, 0, 12'h0C5, 16'hBEEF};
        vecs[1]  = '{12'h100, 12'h03F, 1'b1, 16'h1111, 0, 0, 0, 12'hFFF, 16'h1111};
        vecs[2]  = '{12'h03F, 12'h040, 1'b1, 16'h2222, 0, 0, 0, 12'hFFF, 16'h2222};
        vecs[3]  = '{12'h010, 12'h001, 1'b1, 16'h3333, 0, 0, 0, 12'h050, 16'h3333};
        vecs[4]  = '{12'h100, 12'h03F, 1'b0, 16'h4444, 0, 0, 0, 12'hFC0, 16'h4444};
        vecs[5]  = '{12'hFFF, 12'hFFF, 1'b0, 16'h5555, 0, 1, 0, 12'hFFF, 16'h5555};
        vecs[6]  = '{12'hFFF, 12'h000, 1'b1, 16'h6666, 1, 0, 0, 12'h03F, 16'h6666};
        vecs[7]  = '{12'h040, 12'h040, 1'b0, 16'h7777, 0, 0, 1, 12'h000, 16'h7777};
        vecs[8]  = '{12'h040, 12'h040, 1'b1, 16'h8888, 0, 0, 0, 12'hFFF, 16'h8888};
        vecs[9]  = '{12'h7A1, 12'h012, 1'b0, 16'h9999, 5, 2, 4, 12'h4A1, 16'h9999};
        vecs[10] = '{12'h03E, 12'h801, 1'b1, 16'hAAAA, 0, 0, 0, 12'hFFE, 16'hAAAA};
        vecs[11] = '{12'h0C1, 12'h085, 1'b0, 16'h0000, 2, 0, 0, 12'h141, 16'h0000};
        for (int i = 0; i < 4096; i++) tex_mem[i] = 16'($urandom);

        // Reset values while held in reset.
        step();
        chk_reset_vals("reset");
        aresetn = 1'b1;

        for (int i = 0; i < 12; i++) begin
            fetch($sformatf("vec%0d", i), vecs[i].tu, vecs[i].tv, vecs[i].cl, vecs[i].rd,
                  vecs[i].gd, vecs[i].rdd, vecs[i].od, vecs[i].ea, vecs[i].et);
        end

        // Stray read data while idle must not disturb the next fetch or the held texel.
        mem_rvalid = 1'b1;
        mem_rdata = 16'h1234;
        step();
        mem_rvalid = 1'b0;
        chk("stray_no_out", out_valid, 0);
        chk("stray_texel_kept", texel, 16'h0000);
        fetch("stray_fetch", 12'h011, 12'h022, 1'b0, 16'h5678, 0, 0, 0, 12'h891, 16'h5678);

        // Reset while waiting for data, then a late response.
        in_valid = 1'b1;
        tu = 12'h005;
        tv = 12'h006;
        clamp = 1'b0;
        step();
        in_valid = 1'b0;
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        aresetn = 1'b0;
        #1;
        chk_reset_vals("midreset");
        step();
        aresetn = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata = 16'hDEAD;
        step();
        mem_rvalid = 1'b0;
        chk_reset_vals("late_rvalid");
        for (int i = 0; i < 3; i++) begin
            step();
            chk("late_no_out", out_valid, 0);
        end

        // First edge after reset release accepts an input.
        aresetn = 1'b0;
        step();
        aresetn = 1'b1;
        fetch("post_reset", 12'h002, 12'h003, 1'b1, 16'hC0DE, 0, 0, 0, 12'h0C2, 16'hC0DE);

        // Back-to-back with everything ready; memory modelled as an array.
        b2b_tu[0] = 12'h001; b2b_tv[0] = 12'h002;
        b2b_tu[1] = 12'h3C0; b2b_tv[1] = 12'h0FF;
        b2b_tu[2] = 12'h07F; b2b_tv[2] = 12'h041;
        for (int k = 0; k < 3; k++) b2b_ea[k] = 12'(model_addr(int'(b2b_tu[k]), int'(b2b_tv[k]), k == 2));
        mem_gnt = 1'b1;
        mem_rvalid = 1'b1;
        out_ready = 1'b1;
        in_valid = 1'b1;
        tu = b2b_tu[0];
        tv = b2b_tv[0];
        clamp = 1'b0;
        nreq = 0;
        nout = 0;
        nacc = 0;
        for (int c = 0; c < 40 && nout < 3; c++) begin
            logic acc;
            if (mem_req) begin
                if (nreq < 3) chk("b2b_addr", mem_addr, b2b_ea[nreq]);
                mem_rdata = tex_mem[mem_addr];
                nreq++;
            end
            if (out_valid) begin
                if (nout < 3) chk("b2b_texel", texel, tex_mem[b2b_ea[nout]]);
                nout++;
            end
            acc = in_ready && in_valid;
            step();
            if (acc) begin
                nacc++;
                if (nacc < 3) begin
                    tu = b2b_tu[nacc];
                    tv = b2b_tv[nacc];
                    clamp = (nacc == 2);
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        for (int c = 0; c < 4; c++) begin
            if (mem_req) nreq++;
            step();
        end
        mem_gnt = 1'b0;
        mem_rvalid = 1'b0;
        out_ready = 1'b0;
        in_valid = 1'b0;
        chk("b2b_requests", nreq, 3);
        chk("b2b_outputs", nout, 3);
        chk("b2b_accepts", nacc, 3);

        // Randomized fetches against the reference addressing model.
        for (int i = 0; i < 40; i++) begin
            logic [11:0] rtu;
            logic [11:0] rtv;
            logic        rcl;
            logic [15:0] rrd;
            rtu = $urandom_range(0, 1) ? 12'($urandom) : 12'($urandom_range(0, 127));
            rtv = $urandom_range(0, 1) ? 12'($urandom) : 12'($urandom_range(0, 127));
            rcl = 1'($urandom);
            rrd = 16'($urandom);
            ea = model_addr(int'(rtu), int'(rtv), rcl);
            fetch($sformatf("rand%0d", i), rtu, rtv, rcl, rrd, $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 2), 12'(ea), rrd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shader_texel_fetch.md
SHADER_TEXEL_FETCH -- requirements
Module: shader_texel_fetch

Interface
REQ-001 The module SHALL have parameter TEX_W_LOG2, default 6, giving log2 of the texture width in texels (1..11).
REQ-002 The module SHALL have parameter TEX_H_LOG2, default 6, giving log2 of the texture height in texels (1..11).
REQ-003 The module SHALL have parameter TEXEL_W, default 16, giving the texel data width in bits.
REQ-004 The module SHALL use one clock and an asynchronous, active-low reset, named as the codebase does.
REQ-005 aclk  input  1  clock; all state changes on its rising edge.
REQ-006 aresetn  input  1  asynchronous active-low reset.
REQ-007 in_valid  input  1  texture coordinate pair is valid.
REQ-008 in_ready  output  1  block can accept a coordinate pair.
REQ-009 tu  input  12  unsigned texel U coordinate from the affine stage.
REQ-010 tv  input  12  unsigned texel V coordinate from the affine stage.
REQ-011 clamp  input  1  addressing mode sampled with tu/tv: 1 = clamp to edge, 0 = wrap.
REQ-012 mem_req  output  1  texture memory read request.
REQ-013 mem_gnt  input  1  memory accepted the request this cycle.
REQ-014 mem_addr  output  TEX_W_LOG2+TEX_H_LOG2  texel address, V in the high bits and U in the low bits.
REQ-015 mem_rvalid  input  1  read data valid.
REQ-016 mem_rdata  input  TEXEL_W  read data.
REQ-017 out_valid  output  1  texel result valid.
REQ-018 out_ready  input  1  downstream accepts the texel.
REQ-019 texel  output  TEXEL_W  fetched texel.

Function
REQ-020 The FSM SHALL have the states IDLE, REQ, WAIT and OUT, and SHALL keep at most one memory read outstanding.
REQ-021 in_ready SHALL be 1 only in IDLE; a handshake (in_valid & in_ready) SHALL latch the computed address and move the FSM to REQ.
REQ-022 In wrap mode, u SHALL be tu[TEX_W_LOG2-1:0] and v SHALL be tv[TEX_H_LOG2-1:0].
REQ-023 In clamp mode, u SHALL be 2^TEX_W_LOG2-1 when tu >= 2^TEX_W_LOG2 and tu[TEX_W_LOG2-1:0] otherwise; v SHALL follow the same rule with TEX_H_LOG2.
REQ-024 Addressing SHALL treat tu/tv as unsigned, with no sign handling.
REQ-025 mem_addr SHALL be {v, u}, registered at the handshake, and SHALL be held stable from REQ until the next handshake.
REQ-026 In REQ, mem_req SHALL be 1; mem_gnt=1 SHALL move the FSM to WAIT, otherwise it SHALL stay in REQ with mem_req held.
REQ-027 mem_req SHALL be 0 in every state other than REQ.
REQ-028 In WAIT, mem_rvalid=1 SHALL capture mem_rdata into texel and move the FSM to OUT.
REQ-029 mem_rvalid SHALL be ignored in IDLE, REQ and OUT; late or stray responses SHALL be discarded.
REQ-030 In OUT, out_valid SHALL be 1 and texel SHALL be held stable; out_ready=1 SHALL move the FSM to IDLE.
REQ-031 A new input SHALL NOT be accepted in the same cycle as the out_ready handshake; in_ready rises in the following cycle.
REQ-032 Minimum latency SHALL be 3 cycles from input handshake to out_valid, given mem_gnt in the first REQ cycle and mem_rvalid in the first WAIT cycle.
REQ-033 Input throughput SHALL be at most one coordinate per 4 cycles.
REQ-034 No outputs SHALL be driven combinationally from inputs, except that the state transitions react to inputs within the same cycle.

Reset
REQ-035 While aresetn=0, the state SHALL be IDLE and all outputs SHALL be: in_ready=1, mem_req=0, mem_addr=0, out_valid=0, texel=0.
REQ-036 Assertion of aresetn in any state SHALL abort the operation in progress with no output produced.
REQ-037 A mem_rvalid arriving after reset is released SHALL be discarded.
REQ-038 After reset release, the first aclk edge SHALL be able to accept an input.

Verification
REQ-039 Wrap, TEX_W_LOG2=TEX_H_LOG2=6: tu=0x045, tv=0x0C3, clamp=0, immediate gnt and rvalid with rdata=0xBEEF -> mem_addr=0x0C5; out_valid 3 cycles after the handshake; texel=0xBEEF.
REQ-040 Clamp: tu=0x100, tv=0x03F, clamp=1 -> mem_addr=0xFFF; with tu=0x03F, tv=0x040 -> mem_addr=0xFFF; with tu=0x010, tv=0x001 -> mem_addr=0x050.
REQ-041 Backpressure: mem_gnt held 0 for 5 cycles -> mem_req=1 and mem_addr stable throughout, in_ready=0; out_ready held 0 for 4 cycles -> texel and out_valid stable, no new input accepted.
REQ-042 Stray data: mem_rvalid=1 with rdata=0x1234 pulsed while IDLE, then a normal fetch returning 0x5678 -> texel=0x5678.
REQ-043 Reset mid-operation: aresetn pulsed low while in WAIT, then mem_rvalid arrives -> outputs at reset values, out_valid never asserted, in_ready=1.
REQ-044 Back-to-back: in_valid held 1 with 3 distinct coordinates and out_ready=1 -> exactly 3 memory requests in order, 3 texels returned in order, each input accepted only in IDLE.
